// File: rtl/line_engine.sv
// line_engine: responder side of the graphics line-engine interface.
// Latches color, frame base and two endpoints, then rasterizes the line with
// integer Bresenham, writing one 32-bit pixel per two-beat DRAM write burst.
// Optional feature: define LE_CLIP_EN to skip pixels outside H_RES x V_RES.
module line_engine #(
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic         clk,
  input  logic         rst,
  output logic         LE_ready,
  input  logic [31:0]  LE_color,
  input  logic [19:0]  LE_point,
  input  logic         LE_color_valid,
  input  logic         LE_point0_valid,
  input  logic         LE_point1_valid,
  input  logic         LE_trigger,
  input  logic [31:0]  LE_frame,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

`ifdef LE_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, INIT, WR0, WR1} state_t;

  state_t state, next_state;

  logic [23:0] color_q;
  logic [31:0] frame_q;
  logic [19:0] p0_q, p1_q;

  logic        steep;
  logic [9:0]  x0_q, y0_q, x1_q, y1_q;
  logic [9:0]  dx, dy;
  logic signed [11:0] err;
  logic        y_down;
  logic [9:0]  cx, cy;

  logic [9:0]  ax0, ay0, ax1, ay1, adx, ady;
  logic [9:0]  sx0, sy0, sx1, sy1;
  logic        s_steep, s_swap;
  logic [9:0]  ddx, ddy;
  logic signed [11:0] err_sub, err_add;
  logic [9:0]  px, py;
  logic [31:0] pix_addr;
  logic [2:0]  word_k;
  logic [15:0] lane_mask, mask0, mask1;
  logic        in_bounds, pixel_en;
  logic        beat0, beat1, step;
  logic        unused_bits;

  assign af_cmd_din  = 3'b000;
  assign unused_bits = ^{LE_color[31:24], pix_addr[31:28], pix_addr[1:0]};

  // Endpoint normalisation: decide steepness, transpose if steep, order by x
  always_comb begin
    ax0 = p0_q[19:10];
    ay0 = p0_q[9:0];
    ax1 = p1_q[19:10];
    ay1 = p1_q[9:0];
    adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    s_steep = ady > adx;
    sx0 = s_steep ? ay0 : ax0;
    sy0 = s_steep ? ax0 : ay0;
    sx1 = s_steep ? ay1 : ax1;
    sy1 = s_steep ? ax1 : ay1;
    s_swap = sx0 > sx1;
  end

  // Bresenham deltas and the error update for one x step
  always_comb begin
    ddx = x1_q - x0_q;
    ddy = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
    err_sub = err - $signed({2'b00, dy});
    err_add = err_sub + $signed({2'b00, dx});
  end

  // Current pixel address, its word slot in the 32-byte burst and lane masks
  always_comb begin
    px = steep ? cy : cx;
    py = steep ? cx : cy;
    pix_addr = frame_q + {10'b0, py, px, 2'b00};
    word_k = pix_addr[4:2];
    lane_mask = ~(16'h000F << {word_k[1:0], 2'b00});
    mask0 = word_k[2] ? 16'hFFFF : lane_mask;
    mask1 = word_k[2] ? lane_mask : 16'hFFFF;
    in_bounds = (int'(px) < H_RES) && (int'(py) < V_RES);
    pixel_en = !CLIP_ON || in_bounds;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: WR0/WR1 wait on FIFO space unless the pixel is skipped
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (LE_trigger) next_state = SETUP;
      SETUP:   next_state = INIT;
      INIT:    next_state = WR0;
      WR0:     if (!pixel_en || (!af_full && !wdf_full)) next_state = WR1;
      WR1:     if (!pixel_en || !wdf_full) next_state = (cx == x1_q) ? IDLE : WR0;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: which beat is pushed this cycle and whether Bresenham steps
  always_comb begin
    beat0 = (state == WR0) && pixel_en && !af_full && !wdf_full;
    beat1 = (state == WR1) && pixel_en && !wdf_full;
    step  = (state == WR1) && (!pixel_en || !wdf_full);
  end

  // Command latches, only writable while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q <= '0;
      frame_q <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
    end else if (state == IDLE) begin
      if (LE_color_valid) begin
        color_q <= LE_color[23:0];
        frame_q <= LE_frame;
      end
      if (LE_point0_valid) p0_q <= LE_point;
      if (LE_point1_valid) p1_q <= LE_point;
    end
  end

  // Line geometry: normalise in SETUP, seed in INIT, step after each pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steep  <= 1'b0;
      x0_q   <= '0;
      y0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      y_down <= 1'b0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      case (state)
        SETUP: begin
          steep <= s_steep;
          if (s_swap) begin
            x0_q <= sx1;
            y0_q <= sy1;
            x1_q <= sx0;
            y1_q <= sy0;
          end else begin
            x0_q <= sx0;
            y0_q <= sy0;
            x1_q <= sx1;
            y1_q <= sy1;
          end
        end
        INIT: begin
          dx     <= ddx;
          dy     <= ddy;
          err    <= $signed({3'b000, ddx[9:1]});
          y_down <= !(y0_q < y1_q);
          cx     <= x0_q;
          cy     <= y0_q;
        end
        WR1: begin
          if (step && (cx != x1_q)) begin
            cx <= cx + 10'd1;
            if (err_sub[11]) begin
              cy  <= y_down ? cy - 10'd1 : cy + 10'd1;
              err <= err_add;
            end else begin
              err <= err_sub;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered FIFO outputs and ready; data held steady between pushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LE_ready     <= 1'b0;
      af_wr_en     <= 1'b0;
      wdf_wr_en    <= 1'b0;
      af_addr_din  <= '0;
      wdf_din      <= '0;
      wdf_mask_din <= 16'hFFFF;
    end else begin
      LE_ready  <= (next_state == IDLE);
      af_wr_en  <= beat0;
      wdf_wr_en <= beat0 | beat1;
      if (beat0) begin
        af_addr_din  <= {8'b0, pix_addr[27:5]};
        wdf_din      <= {4{8'h00, color_q}};
        wdf_mask_din <= mask0;
      end else if (beat1) begin
        wdf_din      <= {4{8'h00, color_q}};
        wdf_mask_din <= mask1;
      end
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed and randomized lines checked against a
// behavioural Bresenham model that predicts every address and data beat.
module tb_line_engine;

  logic         clk;
  logic         rst;
  logic         LE_ready;
  logic [31:0]  LE_color;
  logic [19:0]  LE_point;
  logic         LE_color_valid;
  logic         LE_point0_valid;
  logic         LE_point1_valid;
  logic         LE_trigger;
  logic [31:0]  LE_frame;
  logic         af_full;
  logic         wdf_full;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  int vectors = 0;
  int miscompares = 0;

  logic [30:0]  got_addr[$];
  logic [127:0] got_data[$];
  logic [15:0]  got_mask[$];
  logic [30:0]  exp_addr[$];
  logic [127:0] exp_data[$];
  logic [15:0]  exp_mask[$];

  line_engine dut (
    .clk(clk),
    .rst(rst),
    .LE_ready(LE_ready),
    .LE_color(LE_color),
    .LE_point(LE_point),
    .LE_color_valid(LE_color_valid),
    .LE_point0_valid(LE_point0_valid),
    .LE_point1_valid(LE_point1_valid),
    .LE_trigger(LE_trigger),
    .LE_frame(LE_frame),
    .af_full(af_full),
    .wdf_full(wdf_full),
    .af_wr_en(af_wr_en),
    .af_cmd_din(af_cmd_din),
    .af_addr_din(af_addr_din),
    .wdf_wr_en(wdf_wr_en),
    .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every FIFO push, sampled mid-cycle
  always @(negedge clk) begin
    if (af_wr_en) got_addr.push_back(af_addr_din);
    if (wdf_wr_en) begin
      got_data.push_back(wdf_din);
      got_mask.push_back(wdf_mask_din);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit pixel_visible(input int px, input int py);
`ifdef LE_CLIP_EN
    return (px < 800) && (py < 600);
`else
    return (px >= 0) && (py >= 0);
`endif
  endfunction

  // Reference: textbook Bresenham over ints, each pixel becomes a 32-byte burst
  task automatic model_line(input logic [31:0] frame, input logic [23:0] color,
                            input int ax0, input int ay0, input int ax1, input int ay1);
    int x0, y0, x1, y1, t, ddx, ddy, err, ystep, y, px, py, w;
    bit steep;
    logic [31:0] a;
    logic [15:0] m;
    exp_addr.delete();
    exp_data.delete();
    exp_mask.delete();
    steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (steep) begin
      x0 = ay0; y0 = ax0; x1 = ay1; y1 = ax1;
    end else begin
      x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    ddx = x1 - x0;
    ddy = iabs(y1 - y0);
    err = ddx / 2;
    ystep = (y0 < y1) ? 1 : -1;
    y = y0;
    for (int x = x0; x <= x1; x++) begin
      px = steep ? y : x;
      py = steep ? x : y;
      if (pixel_visible(px, py)) begin
        a = frame + 32'((py * 1024 + px) * 4);
        w = int'(a[4:2]);
        exp_addr.push_back({8'b0, a[27:5]});
        for (int beat = 0; beat < 2; beat++) begin
          m = 16'hFFFF;
          if (w / 4 == beat) m[4 * (w % 4) +: 4] = 4'h0;
          exp_mask.push_back(m);
          exp_data.push_back({4{8'h00, color}});
        end
      end
      err = err - ddy;
      if (err < 0) begin
        y = y + ystep;
        err = err + ddx;
      end
    end
  endtask

  task automatic program_line(input logic [31:0] frame, input logic [23:0] color,
                              input int x0, input int y0, input int x1, input int y1);
    @(posedge clk); #1;
    LE_frame = frame;
    LE_color = {8'hA5, color};
    LE_color_valid = 1'b1;
    @(posedge clk); #1;
    LE_color_valid = 1'b0;
    LE_point = {x0[9:0], y0[9:0]};
    LE_point0_valid = 1'b1;
    @(posedge clk); #1;
    LE_point0_valid = 1'b0;
    LE_point = {x1[9:0], y1[9:0]};
    LE_point1_valid = 1'b1;
    @(posedge clk); #1;
    LE_point1_valid = 1'b0;
    LE_point = 20'($urandom);
  endtask

  // Trigger a line and watch it; kind 1 = af_full stall in WR0, kind 2 = wdf_full stall in WR1
  task automatic run_line(input string tag, input int budget, input int kind,
                          input bit with_p1, input logic [19:0] p1,
                          output int af_n, output int rdy_n);
    logic [30:0] hold_addr;
    got_addr.delete();
    got_data.delete();
    got_mask.delete();
    hold_addr = af_addr_din;
    @(posedge clk); #1;
    LE_trigger = 1'b1;
    if (with_p1) begin
      LE_point = p1;
      LE_point1_valid = 1'b1;
    end
    if (kind == 1) af_full = 1'b1;
    @(posedge clk); #1;
    LE_trigger = 1'b0;
    LE_point1_valid = 1'b0;
    af_n = -1;
    rdy_n = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      LE_color_valid = 1'b0;
      LE_point0_valid = 1'b0;
      if (af_n < 0 && af_wr_en) af_n = n;
      if (kind == 1 && n <= 8) begin
        check({tag, "_stall_af_en"}, 128'(af_wr_en), 128'(0));
        check({tag, "_stall_wdf_en"}, 128'(wdf_wr_en), 128'(0));
        check({tag, "_stall_addr_hold"}, 128'(af_addr_din), 128'(hold_addr));
        if (n == 8) af_full = 1'b0;
      end
      if (kind == 2) begin
        if (n == 4) wdf_full = 1'b1;
        if (n >= 5 && n <= 8) check({tag, "_wstall_wdf_en"}, 128'(wdf_wr_en), 128'(0));
        if (n == 8) wdf_full = 1'b0;
        if (n == 9) check({tag, "_wstall_beat1"}, 128'(wdf_wr_en), 128'(1));
      end
      if (LE_ready) begin
        rdy_n = n;
        break;
      end
      if (n == 5 && kind == 0) begin
        LE_color = ~LE_color;
        LE_frame = LE_frame ^ 32'h0000_4000;
        LE_point = 20'($urandom);
        LE_color_valid = 1'b1;
        LE_point0_valid = 1'b1;
      end
    end
    if (rdy_n < 0) check({tag, "_ready_timeout"}, 128'(LE_ready), 128'(1));
    af_full = 1'b0;
    wdf_full = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic compare_line(input string tag);
    check({tag, "_af_count"}, 128'(got_addr.size()), 128'(exp_addr.size()));
    check({tag, "_wdf_count"}, 128'(got_data.size()), 128'(exp_data.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 128'(got_addr[i]), 128'(exp_addr[i]));
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s_mask%0d", tag, i), 128'(got_mask[i]), 128'(exp_mask[i]));
    end
  endtask

  initial begin
    int af_n, rdy_n, x0, y0, x1, y1, len;
    logic [31:0] fr;
    logic [23:0] co;

    rst = 1'b0;
    LE_color = '0;
    LE_point = '0;
    LE_color_valid = 1'b0;
    LE_point0_valid = 1'b0;
    LE_point1_valid = 1'b0;
    LE_trigger = 1'b0;
    LE_frame = '0;
    af_full = 1'b0;
    wdf_full = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_af_wr_en", 128'(af_wr_en), 128'(0));
    check("rst_wdf_wr_en", 128'(wdf_wr_en), 128'(0));
    check("rst_af_addr", 128'(af_addr_din), 128'(0));
    check("rst_wdf_din", wdf_din, 128'(0));
    check("rst_mask", 128'(wdf_mask_din), 128'(16'hFFFF));
    check("rst_cmd", 128'(af_cmd_din), 128'(0));
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(LE_ready), 128'(1));

    // Horizontal 4-pixel line in one burst row; latency and ready timing
    program_line(32'h1040_0000, 24'hFF0000, 0, 0, 3, 0);
    model_line(32'h1040_0000, 24'hFF0000, 0, 0, 3, 0);
    run_line("hline", 100, 0, 1'b0, 20'h0, af_n, rdy_n);
    check("hline_first_af_latency", 128'(af_n), 128'(4));
    check("hline_ready_cycle", 128'(rdy_n), 128'(3 + 2 * 4));
    compare_line("hline");

    // Degenerate line; point1 delivered together with the trigger
    program_line(32'h0000_2000, 24'h00FF00, 5, 5, 9, 9);
    model_line(32'h0000_2000, 24'h00FF00, 5, 5, 5, 5);
    run_line("dot", 100, 0, 1'b1, {10'd5, 10'd5}, af_n, rdy_n);
    check("dot_ready_cycle", 128'(rdy_n), 128'(5));
    compare_line("dot");

    // Steep, reversed line
    program_line(32'h0012_3460, 24'h0000FF, 2, 10, 0, 0);
    model_line(32'h0012_3460, 24'h0000FF, 2, 10, 0, 0);
    run_line("steep", 200, 0, 1'b0, 20'h0, af_n, rdy_n);
    check("steep_pixels", 128'(got_addr.size()), 128'(11));
    compare_line("steep");

    // Address FIFO full while the first pixel waits in WR0
    program_line(32'h0300_0000, 24'h123456, 10, 20, 17, 23);
    model_line(32'h0300_0000, 24'h123456, 10, 20, 17, 23);
    run_line("afstall", 200, 1, 1'b0, 20'h0, af_n, rdy_n);
    check("afstall_first_af", 128'(af_n), 128'(9));
    compare_line("afstall");

    // Write-data FIFO full while the second beat waits in WR1
    program_line(32'h0040_0010, 24'hABCDEF, 30, 40, 24, 43);
    model_line(32'h0040_0010, 24'hABCDEF, 30, 40, 24, 43);
    run_line("wdfstall", 200, 2, 1'b0, 20'h0, af_n, rdy_n);
    compare_line("wdfstall");

    // Reset in WR1 of the third pixel, then a clean line
    program_line(32'h0000_0000, 24'h777777, 0, 0, 9, 3);
    got_addr.delete();
    @(posedge clk); #1 LE_trigger = 1'b1;
    @(posedge clk); #1 LE_trigger = 1'b0;
    repeat (8) @(negedge clk);
    check("prereset_wdf_en", 128'(wdf_wr_en), 128'(1));
    rst = 1'b0;
    #1;
    check("midreset_af_en", 128'(af_wr_en), 128'(0));
    check("midreset_wdf_en", 128'(wdf_wr_en), 128'(0));
    check("midreset_mask", 128'(wdf_mask_din), 128'(16'hFFFF));
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 128'(LE_ready), 128'(1));
    program_line(32'h0008_0000, 24'h55AA55, 100, 50, 93, 47);
    model_line(32'h0008_0000, 24'h55AA55, 100, 50, 93, 47);
    run_line("postreset", 200, 0, 1'b0, 20'h0, af_n, rdy_n);
    compare_line("postreset");

`ifdef LE_CLIP_EN
    program_line(32'h0000_0000, 24'h0F0F0F, 795, 0, 804, 0);
    model_line(32'h0000_0000, 24'h0F0F0F, 795, 0, 804, 0);
    run_line("clip", 200, 0, 1'b0, 20'h0, af_n, rdy_n);
    check("clip_bursts", 128'(got_addr.size()), 128'(5));
    compare_line("clip");
`endif

    // Randomized short lines anywhere in the 10-bit space
    for (int i = 0; i < 12; i++) begin
      fr = $urandom;
      co = 24'($urandom);
      x0 = int'($urandom_range(0, 1023));
      y0 = int'($urandom_range(0, 1023));
      x1 = x0 + int'($urandom_range(0, 60)) - 30;
      y1 = y0 + int'($urandom_range(0, 60)) - 30;
      if (x1 < 0) x1 = 0;
      if (x1 > 1023) x1 = 1023;
      if (y1 < 0) y1 = 0;
      if (y1 > 1023) y1 = 1023;
      len = (iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
      program_line(fr, co, x0, y0, x1, y1);
      model_line(fr, co, x0, y0, x1, y1);
      run_line($sformatf("rnd%0d", i), 2 * (len + 1) + 20, 0, 1'b0, 20'h0, af_n, rdy_n);
      check($sformatf("rnd%0d_ready_cycle", i), 128'(rdy_n), 128'(3 + 2 * (len + 1)));
      compare_line($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
